// File: rtl/ptw_pte_responder.sv
// PTW PTE read responder: two-phase (index, then tag) request port, optional PTE cache, single-outstanding downstream read.
// Optional macro PTW_PTE_CACHE_EN enables the fully-associative PTE cache; without it every tag phase goes downstream.
module ptw_pte_responder #(
  parameter int NrEntries  = 4,
  parameter int IndexWidth = 12,
  parameter int TagWidth   = 44,
  parameter int PLEN       = 56,
  parameter int XLEN       = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_data_req_i,
  input  logic [IndexWidth-1:0] req_address_index_i,
  output logic                  req_data_gnt_o,
  input  logic [TagWidth-1:0]   req_address_tag_i,
  input  logic                  req_tag_valid_i,
  input  logic                  req_kill_req_i,
  output logic                  req_data_rvalid_o,
  output logic [XLEN-1:0]       req_data_rdata_o,
  output logic                  mem_req_o,
  output logic [PLEN-1:0]       mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i
);

  localparam int AddrW = PLEN - 3;
  localparam int PtrW  = (NrEntries > 1) ? $clog2(NrEntries) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_TAG, MEM_REQ, MEM_WAIT, RESP} state_e;

  state_e state_q, state_d;

  logic [IndexWidth-4:0] index_q;
  logic [AddrW-1:0]      addr_q;
  logic [AddrW-1:0]      lookup_addr;
  logic                  killed_q;
  logic                  mem_killed;
  logic [XLEN-1:0]       rdata_q;
  logic                  hit_taken;
  logic [XLEN-1:0]       hit_data;
  logic                  tag_accept;
  logic                  unused_index_bits;

  // Only the 8-byte-aligned part of the address participates in matching.
  assign lookup_addr       = {req_address_tag_i, index_q};
  assign unused_index_bits = ^req_address_index_i[2:0];
  assign tag_accept        = (state_q == WAIT_TAG) && req_tag_valid_i && !req_kill_req_i;
  assign mem_killed        = killed_q || req_kill_req_i;

  assign mem_req_o         = (state_q == MEM_REQ);
  assign mem_addr_o        = {addr_q, 3'b000};
  assign req_data_rvalid_o = (state_q == RESP);
  assign req_data_rdata_o  = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_data_gnt_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_data_gnt_o = req_data_req_i;
        if (req_data_req_i) state_d = WAIT_TAG;
      end
      WAIT_TAG: begin
        if (req_kill_req_i)       state_d = IDLE;
        else if (req_tag_valid_i) state_d = hit_taken ? RESP : MEM_REQ;
      end
      MEM_REQ: begin
        if (mem_gnt_i) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_rvalid_i) state_d = mem_killed ? IDLE : RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request bookkeeping: latched address, kill tracking and the response register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      index_q  <= '0;
      addr_q   <= '0;
      killed_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (state_q == IDLE && req_data_req_i) index_q <= req_address_index_i[IndexWidth-1:3];
      if (tag_accept) begin
        addr_q   <= lookup_addr;
        killed_q <= 1'b0;
        if (hit_taken) rdata_q <= hit_data;
      end
      if ((state_q == MEM_REQ || state_q == MEM_WAIT) && req_kill_req_i) killed_q <= 1'b1;
      if (state_q == MEM_WAIT && mem_rvalid_i && !mem_killed) rdata_q <= mem_rdata_i;
    end
  end

`ifdef PTW_PTE_CACHE_EN
  logic [NrEntries-1:0] valid_q;
  logic [AddrW-1:0]     tag_q  [NrEntries];
  logic [XLEN-1:0]      data_q [NrEntries];
  logic [PtrW-1:0]      ptr_q;
  logic                 no_fill_q;
  logic                 lookup_hit;
  logic                 fill;

  always_comb begin
    lookup_hit = 1'b0;
    hit_data   = '0;
    for (int i = 0; i < NrEntries; i++) begin
      if (valid_q[i] && tag_q[i] == lookup_addr) begin
        lookup_hit = 1'b1;
        hit_data   = data_q[i];
      end
    end
  end

  // A flush coinciding with the tag phase still sees the old entries but must not hit.
  assign hit_taken = lookup_hit && !flush_i;
  assign fill      = (state_q == MEM_WAIT) && mem_rvalid_i && !mem_killed &&
                     mem_rdata_i[0] && !no_fill_q && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      ptr_q     <= '0;
      no_fill_q <= 1'b0;
    end else begin
      if (flush_i) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[ptr_q] <= 1'b1;
        ptr_q          <= ptr_q + PtrW'(1);
      end
      if (tag_accept) no_fill_q <= flush_i;
      else if ((state_q == MEM_REQ || state_q == MEM_WAIT) && flush_i) no_fill_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[ptr_q]  <= addr_q;
      data_q[ptr_q] <= mem_rdata_i;
    end
  end
`else
  logic unused_flush;

  assign hit_taken    = 1'b0;
  assign hit_data     = '0;
  assign unused_flush = flush_i;
`endif

endmodule

// File: tb/tb_ptw_pte_responder.sv
// Directed self-checking bench for ptw_pte_responder; expectations follow PTW_PTE_CACHE_EN when it is defined.
module tb_ptw_pte_responder;

`ifdef PTW_PTE_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req = 1'b0;
  logic [11:0] idx = '0;
  logic        gnt;
  logic [43:0] tag = '0;
  logic        tag_valid = 1'b0;
  logic        kill = 1'b0;
  logic        rvalid;
  logic [63:0] rdata;
  logic        mem_req;
  logic [55:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  ptw_pte_responder dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .flush_i             (flush),
    .req_data_req_i      (req),
    .req_address_index_i (idx),
    .req_data_gnt_o      (gnt),
    .req_address_tag_i   (tag),
    .req_tag_valid_i     (tag_valid),
    .req_kill_req_i      (kill),
    .req_data_rvalid_o   (rvalid),
    .req_data_rdata_o    (rdata),
    .mem_req_o           (mem_req),
    .mem_addr_o          (mem_addr),
    .mem_gnt_i           (mem_gnt),
    .mem_rvalid_i        (mem_rvalid),
    .mem_rdata_i         (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One full PTW read; mem data arrives 3 cycles into MEM_WAIT.
  task automatic apply_stimulus(input logic [11:0] a_idx, input logic [43:0] a_tag,
                                input logic [63:0] pte, input bit exp_hit, input int stall,
                                input bit flush_tag, input bit flush_wait, input bit kill_wait);
    logic [55:0] exp_addr;
    exp_addr = {a_tag, a_idx[11:3], 3'b000};
    @(posedge clk); #1;
    req = 1'b1; idx = a_idx;
    #1 check_output("gnt_idle", gnt, 1);
    @(posedge clk); #1;
    req = 1'b0; tag = a_tag; tag_valid = 1'b1; flush = flush_tag;
    #1 check_output("gnt_wait_tag", gnt, 0);
    @(posedge clk); #1;
    tag_valid = 1'b0; flush = 1'b0;
    #1;
    if (exp_hit) begin
      check_output("hit_rvalid", rvalid, 1);
      check_output("hit_rdata", rdata, pte);
      check_output("hit_mem_req", mem_req, 0);
      @(posedge clk); #2;
      check_output("hit_rvalid_drop", rvalid, 0);
    end else begin
      check_output("miss_rvalid_early", rvalid, 0);
      for (int c = 0; c < stall; c++) begin
        req = 1'b1;
        #1;
        check_output("stall_mem_req", mem_req, 1);
        check_output("stall_mem_addr", mem_addr, exp_addr);
        check_output("stall_gnt", gnt, 0);
        @(posedge clk); #1;
      end
      req = 1'b0;
      check_output("miss_mem_req", mem_req, 1);
      check_output("miss_mem_addr", mem_addr, exp_addr);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0; kill = kill_wait; flush = flush_wait;
      #1 check_output("mem_req_drop", mem_req, 0);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        kill = 1'b0; flush = 1'b0;
        #1 check_output("wait_rvalid", rvalid, 0);
      end
      mem_rvalid = 1'b1; mem_rdata = pte;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = '0;
      #1;
      if (kill_wait) begin
        check_output("killed_rvalid", rvalid, 0);
      end else begin
        check_output("miss_rvalid", rvalid, 1);
        check_output("miss_rdata", rdata, pte);
      end
      @(posedge clk); #2;
      check_output("miss_rvalid_drop", rvalid, 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("rst_rvalid", rvalid, 0);
    check_output("rst_mem_req", mem_req, 0);
    check_output("rst_rdata", rdata, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_gnt", gnt, 0);

    // Miss, then the same address again.
    apply_stimulus(12'h128, 44'h80000, 64'h2000_0401, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(12'h128, 44'h80000, 64'h2000_0401, CacheEn, 0, 1'b0, 1'b0, 1'b0);
    // Flush together with the tag phase forces a miss and suppresses the fill.
    apply_stimulus(12'h128, 44'h80000, 64'h2000_0401, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(12'h128, 44'h80000, 64'h2000_0401, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Invalid PTE is returned but never cached.
    apply_stimulus(12'h200, 44'h80001, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(12'h200, 44'h80001, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Kill in WAIT_TAG wins over a simultaneous tag_valid.
    @(posedge clk); #1;
    req = 1'b1; idx = 12'h128;
    #1 check_output("kill_gnt", gnt, 1);
    @(posedge clk); #1;
    req = 1'b0; tag = 44'h80000; tag_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    tag_valid = 1'b0; kill = 1'b0;
    #1;
    check_output("kill_tag_rvalid", rvalid, 0);
    check_output("kill_tag_mem_req", mem_req, 0);
    req = 1'b1;
    #1 check_output("kill_tag_idle_gnt", gnt, 1);
    req = 1'b0;
    @(posedge clk); #2;
    check_output("kill_tag_rvalid2", rvalid, 0);
    check_output("kill_tag_mem_req2", mem_req, 0);

    // Kill during MEM_WAIT drains the response silently; no fill.
    apply_stimulus(12'h300, 44'h80002, 64'h1F, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(12'h300, 44'h80002, 64'h1F, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Fill four entries, flush, first address must miss again.
    apply_stimulus(12'h010, 44'h90000, 64'h401, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(12'h018, 44'h90000, 64'h801, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(12'h020, 44'h90000, 64'hC01, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(12'h028, 44'h90000, 64'h1001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(12'h010, 44'h90000, 64'h401, CacheEn, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    apply_stimulus(12'h010, 44'h90000, 64'h401, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Round-robin: five fills, oldest one is evicted.
    for (int i = 0; i < 5; i++)
      apply_stimulus(12'h040 + 12'(8 * i), 44'hA0000, 64'h3000_0001 + 64'(i << 10), 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++)
      apply_stimulus(12'h040 + 12'(8 * i), 44'hA0000, 64'h3000_0001 + 64'(i << 10), CacheEn, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(12'h040, 44'hA0000, 64'h3000_0001, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Flush during MEM_WAIT: response delivered, not cached.
    apply_stimulus(12'h500, 44'hB0000, 64'hCF, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(12'h500, 44'hB0000, 64'hCF, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Downstream grant stalled for 10 cycles.
    apply_stimulus(12'h6F8, 44'hC0001, 64'h55, 1'b0, 10, 1'b0, 1'b0, 1'b0);

    // Reset in MEM_REQ: back to IDLE, cache emptied.
    @(posedge clk); #1;
    req = 1'b1; idx = 12'h700;
    @(posedge clk); #1;
    req = 1'b0; tag = 44'hD0000; tag_valid = 1'b1;
    @(posedge clk); #1;
    tag_valid = 1'b0;
    #1 check_output("midrst_mem_req_before", mem_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("midrst_mem_req", mem_req, 0);
    check_output("midrst_rvalid", rvalid, 0);
    apply_stimulus(12'h060, 44'hA0000, 64'h3000_0801, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
